retire_wb_buffer: RTL and testbench

Retire-side writer for the physical register file: accepts up to two retiring results per cycle, holds them in order in a small circular queue, and drains up to two per cycle onto the register file's writeback request ports c and d. It also answers a combinational pending-write query so dispatch can pick up values that have retired but are not yet in the register file.

---
 rtl/retire_wb_buffer_pkg.sv | 36 +++
 rtl/retire_wb_buffer_wb_fifo2.sv | 59 +++++
 rtl/retire_wb_buffer.sv | 100 ++++++++++
 tb/tb_retire_wb_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/retire_wb_buffer_pkg.sv
// Shared types for the retire-side writeback buffer: register-file request/response
// packing and the queued writeback entry.
package retire_wb_buffer_pkg;

  localparam int PREG_W = 7;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              RegWrite;
    logic [PREG_W-1:0] rs1;
    logic [PREG_W-1:0] rs2;
    logic [PREG_W-1:0] rd;
    logic [DATA_W-1:0] wr_data;
  } regReqStruct;

  typedef struct packed {
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
  } regRespStruct;

  typedef struct packed {
    logic [PREG_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wbEntryStruct;

  // A write request for a queued entry; read-port fields stay zero.
  function automatic regReqStruct make_write(input wbEntryStruct e);
    regReqStruct r;
    r          = '0;
    r.RegWrite = 1'b1;
    r.rd       = e.rd;
    r.wr_data  = e.data;
    return r;
  endfunction

endpackage

// File: rtl/retire_wb_buffer_wb_fifo2.sv
// Two-in / two-out circular queue of writeback entries. Exposes every slot in age
// order (index 0 = head) with a matching occupancy-valid vector.
module wb_fifo2
  import retire_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 push_cnt_i,
  input  wbEntryStruct               push0_i,
  input  wbEntryStruct               push1_i,
  input  logic [1:0]                 pop_cnt_i,
  output wbEntryStruct [DEPTH-1:0]   age_entry_o,
  output logic [DEPTH-1:0]           age_valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   head_q, head_d;
  logic [AW:0]   tail_q, tail_d;
  logic [AW-1:0] tail_idx, tail_idx1;
  wbEntryStruct  mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign head_d    = head_q + (AW+1)'(pop_cnt_i);
  assign tail_d    = tail_q + (AW+1)'(push_cnt_i);
  assign tail_idx  = tail_q[AW-1:0];
  assign tail_idx1 = tail_idx + AW'(1);
  assign count_o   = tail_q - head_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_cnt_i != 2'd0) mem_q[tail_idx]  <= push0_i;
      if (push_cnt_i == 2'd2) mem_q[tail_idx1] <= push1_i;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_age
      logic [AW-1:0] rd_idx;
      assign rd_idx          = head_q[AW-1:0] + AW'(gi);
      assign age_entry_o[gi] = mem_q[rd_idx];
      assign age_valid_o[gi] = (count_o > (AW+1)'(gi));
    end
  endgenerate

endmodule

// File: rtl/retire_wb_buffer.sv
// Retire-side register-file writer: filters x0 results, queues them in order, drains
// up to two per cycle onto request ports c/d and answers pending-write queries.
module retire_wb_buffer
  import retire_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in0_valid,
  input  logic [PREG_W-1:0]       in0_rd,
  input  logic [DATA_W-1:0]       in0_data,
  input  logic                    in1_valid,
  input  logic [PREG_W-1:0]       in1_rd,
  input  logic [DATA_W-1:0]       in1_data,
  output logic                    in_ready,
  input  logic                    hold,
  output regReqStruct             request_c,
  output regReqStruct             request_d,
  input  logic [PREG_W-1:0]       query_preg,
  output logic                    query_hit,
  output logic [DATA_W-1:0]       query_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                     in_ready_q, in_ready_d;
  logic                     acc0, acc1;
  logic [1:0]               push_cnt, pop_cnt;
  wbEntryStruct             entry0, entry1, push0;
  wbEntryStruct [DEPTH-1:0] age_entry;
  logic [DEPTH-1:0]         age_valid;
  logic                     drive_c, drive_d, same_rd;
  logic [CW-1:0]            count_next;

  assign entry0   = '{rd: in0_rd, data: in0_data};
  assign entry1   = '{rd: in1_rd, data: in1_data};
  assign acc0     = in_ready_q & in0_valid & (in0_rd != '0);
  assign acc1     = in_ready_q & in1_valid & (in1_rd != '0);
  assign push_cnt = {1'b0, acc0} + {1'b0, acc1};
  // Accepted entries are packed so the older survivor always lands at the tail.
  assign push0    = acc0 ? entry0 : entry1;

  assign drive_c = ~hold & (count != '0);
  assign drive_d = ~hold & (count >= CW'(2));
  assign pop_cnt = {1'b0, drive_c} + {1'b0, drive_d};
  assign same_rd = drive_d & (age_entry[0].rd == age_entry[1].rd);

  wb_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_cnt_i  (push_cnt),
    .push0_i     (push0),
    .push1_i     (entry1),
    .pop_cnt_i   (pop_cnt),
    .age_entry_o (age_entry),
    .age_valid_o (age_valid),
    .count_o     (count)
  );

  // Both same-rd entries are popped; only the younger one reaches the register file.
  always_comb begin
    request_c = '0;
    request_d = '0;
    if (drive_c && !same_rd) request_c = make_write(age_entry[0]);
    if (drive_d)             request_d = make_write(age_entry[1]);
  end

  assign count_next = count + CW'(push_cnt) - CW'(pop_cnt);
  assign in_ready_d = (count_next <= CW'(DEPTH - 2));
  assign in_ready   = in_ready_q;

  always_ff @(posedge clk) begin
    if (reset) in_ready_q <= 1'b1;
    else       in_ready_q <= in_ready_d;
  end

  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (age_entry[k].rd == query_preg)) begin
        query_hit  = 1'b1;
        query_data = age_entry[k].data;
      end
    end
  end

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (reset)
    !in_ready_q |-> !(in0_valid || in1_valid));
  a_no_x0_write_c: assert property (@(posedge clk) disable iff (reset)
    request_c.RegWrite |-> (request_c.rd != '0));
  a_no_x0_write_d: assert property (@(posedge clk) disable iff (reset)
    request_d.RegWrite |-> (request_d.rd != '0));
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= CW'(DEPTH));

endmodule

// File: tb/tb_retire_wb_buffer.sv
// Bench for retire_wb_buffer: directed vector table, multi-cycle sequences and
// randomized traffic against a queue-based reference model.
module tb_retire_wb_buffer;
  import retire_wb_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in0_valid, in1_valid, hold;
  logic [PREG_W-1:0] in0_rd, in1_rd, query_preg;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              in_ready, query_hit;
  regReqStruct       request_c, request_d;
  logic [DATA_W-1:0] query_data;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  retire_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in0_valid  (in0_valid),
    .in0_rd     (in0_rd),
    .in0_data   (in0_data),
    .in1_valid  (in1_valid),
    .in1_rd     (in1_rd),
    .in1_data   (in1_data),
    .in_ready   (in_ready),
    .hold       (hold),
    .request_c  (request_c),
    .request_d  (request_d),
    .query_preg (query_preg),
    .query_hit  (query_hit),
    .query_data (query_data),
    .count      (count)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: the queued writes, oldest first, and the registered ready flag.
  wbEntryStruct mq[$];
  bit           mready = 1'b1;

  typedef struct {
    logic              v0;
    logic [PREG_W-1:0] rd0;
    logic [DATA_W-1:0] d0;
    logic              v1;
    logic [PREG_W-1:0] rd1;
    logic [DATA_W-1:0] d1;
    logic              h;
    logic [PREG_W-1:0] q;
    int                e_count;
    logic              e_ready;
    regReqStruct       e_c;
    regReqStruct       e_d;
    logic              e_hit;
    logic [DATA_W-1:0] e_qd;
  } vec_t;

  vec_t vecs[13];

  function automatic regReqStruct mk(input bit we, input logic [PREG_W-1:0] rd,
                                     input logic [DATA_W-1:0] d);
    regReqStruct r;
    r          = '0;
    r.RegWrite = we;
    r.rd       = rd;
    r.wr_data  = d;
    return r;
  endfunction

  function automatic vec_t mv(input logic v0, input int rd0, input logic [31:0] d0,
                              input logic v1, input int rd1, input logic [31:0] d1,
                              input logic h, input int q, input int ecnt,
                              input regReqStruct ec, input regReqStruct ed,
                              input logic ehit, input logic [31:0] eqd);
    vec_t v;
    v.v0 = v0; v.rd0 = PREG_W'(rd0); v.d0 = d0;
    v.v1 = v1; v.rd1 = PREG_W'(rd1); v.d1 = d1;
    v.h = h; v.q = PREG_W'(q);
    v.e_count = ecnt; v.e_ready = 1'b1;
    v.e_c = ec; v.e_d = ed; v.e_hit = ehit; v.e_qd = eqd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input int rd0, input logic [31:0] d0,
                       input logic v1, input int rd1, input logic [31:0] d1,
                       input logic h, input int q);
    reset = rst;
    in0_valid = v0; in0_rd = PREG_W'(rd0); in0_data = d0;
    in1_valid = v1; in1_rd = PREG_W'(rd1); in1_data = d1;
    hold = h; query_preg = PREG_W'(q);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input bit do_chk, input int tv);
    regReqStruct       ec, ed;
    logic              eh;
    logic [DATA_W-1:0] eq;
    wbEntryStruct      e;
    int                n;
    @(negedge clk);
    ec = '0; ed = '0; eh = 1'b0; eq = '0;
    if (!hold && mq.size() >= 1) ec = mk(1'b1, mq[0].rd, mq[0].data);
    if (!hold && mq.size() >= 2) begin
      ed = mk(1'b1, mq[1].rd, mq[1].data);
      if (mq[0].rd == mq[1].rd) ec = '0;
    end
    foreach (mq[i]) if (mq[i].rd == query_preg) begin eh = 1'b1; eq = mq[i].data; end
    if (do_chk) begin
      chk("count",      64'(count),      64'(mq.size()));
      chk("in_ready",   64'(in_ready),   64'(mready));
      chk("request_c",  64'(request_c),  64'(ec));
      chk("request_d",  64'(request_d),  64'(ed));
      chk("query_hit",  64'(query_hit),  64'(eh));
      chk("query_data", 64'(query_data), 64'(eq));
    end
    if (tv >= 0) begin
      chk($sformatf("vec%0d_count", tv),  64'(count),      64'(vecs[tv].e_count));
      chk($sformatf("vec%0d_ready", tv),  64'(in_ready),   64'(vecs[tv].e_ready));
      chk($sformatf("vec%0d_req_c", tv),  64'(request_c),  64'(vecs[tv].e_c));
      chk($sformatf("vec%0d_req_d", tv),  64'(request_d),  64'(vecs[tv].e_d));
      chk($sformatf("vec%0d_hit", tv),    64'(query_hit),  64'(vecs[tv].e_hit));
      chk($sformatf("vec%0d_qdata", tv),  64'(query_data), 64'(vecs[tv].e_qd));
    end
    @(posedge clk);
    if (reset) begin
      mq.delete();
      mready = 1'b1;
    end else begin
      n = hold ? 0 : ((mq.size() >= 2) ? 2 : mq.size());
      repeat (n) void'(mq.pop_front());
      if (mready) begin
        if (in0_valid && in0_rd != '0) begin e.rd = in0_rd; e.data = in0_data; mq.push_back(e); end
        if (in1_valid && in1_rd != '0) begin e.rd = in1_rd; e.data = in1_data; mq.push_back(e); end
      end
      mready = ((DEPTH - mq.size()) >= 2);
    end
    cyc++;
    #1;
  endtask

  initial begin
    regReqStruct z;
    z = '0;
    vecs[0]  = mv(1, 5, 32'hA5A5_0001, 1, 9, 32'h9, 0, 5, 0, z, z, 0, 0);
    vecs[1]  = mv(0, 0, 0, 0, 0, 0, 0, 9, 2, mk(1, 5, 32'hA5A5_0001), mk(1, 9, 32'h9), 1, 32'h9);
    vecs[2]  = mv(0, 0, 0, 0, 0, 0, 0, 9, 0, z, z, 0, 0);
    vecs[3]  = mv(1, 0, 32'hFFFF_FFFF, 1, 3, 32'h33, 0, 0, 0, z, z, 0, 0);
    vecs[4]  = mv(0, 0, 0, 0, 0, 0, 0, 3, 1, mk(1, 3, 32'h33), z, 1, 32'h33);
    vecs[5]  = mv(0, 0, 0, 0, 0, 0, 0, 3, 0, z, z, 0, 0);
    vecs[6]  = mv(1, 12, 32'h1, 1, 12, 32'h2, 1, 12, 0, z, z, 0, 0);
    vecs[7]  = mv(0, 0, 0, 0, 0, 0, 1, 12, 2, z, z, 1, 32'h2);
    vecs[8]  = mv(0, 0, 0, 0, 0, 0, 0, 12, 2, z, mk(1, 12, 32'h2), 1, 32'h2);
    vecs[9]  = mv(0, 0, 0, 0, 0, 0, 0, 12, 0, z, z, 0, 0);
    vecs[10] = mv(0, 4, 32'hDEAD, 1, 7, 32'h77, 0, 4, 0, z, z, 0, 0);
    vecs[11] = mv(0, 0, 0, 0, 0, 0, 0, 4, 1, mk(1, 7, 32'h77), z, 0, 0);
    vecs[12] = mv(0, 0, 0, 0, 0, 0, 0, 7, 0, z, z, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, -1);
    step(1, -1);

    for (int i = 0; i < 13; i++) begin
      drive(0, vecs[i].v0, int'(vecs[i].rd0), vecs[i].d0, vecs[i].v1, int'(vecs[i].rd1),
            vecs[i].d1, vecs[i].h, int'(vecs[i].q));
      step(1, i);
    end

    // Fill under hold across the pointer wrap, then drain.
    for (int i = 0; i < 10 && mready; i++) begin
      drive(0, 1, 20 + 2 * i, 32'h100 + i, 1, 21 + 2 * i, 32'h200 + i, 1, 21);
      step(1, -1);
    end
    chk("fill_count", 64'(count), 64'(DEPTH));
    chk("fill_ready", 64'(in_ready), 64'(0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 25);
    repeat (5) step(1, -1);
    chk("drain_count", 64'(count), 64'(0));

    // Enqueue two while releasing hold with three queued: occupancy stays at three.
    drive(0, 1, 50, 32'h50, 1, 51, 32'h51, 1, 50);
    step(1, -1);
    drive(0, 1, 52, 32'h52, 0, 0, 0, 1, 52);
    step(1, -1);
    chk("simul_pre", 64'(count), 64'(3));
    drive(0, 1, 53, 32'h53, 1, 54, 32'h54, 0, 53);
    step(1, -1);
    chk("simul_post", 64'(count), 64'(3));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 54);
    repeat (3) step(1, -1);

    // Reset in mid-operation with four entries queued.
    drive(0, 1, 60, 32'h60, 1, 61, 32'h61, 1, 60);
    step(1, -1);
    drive(0, 1, 62, 32'h62, 1, 63, 32'h63, 1, 60);
    step(1, -1);
    chk("pre_rst_count", 64'(count), 64'(4));
    drive(1, 0, 0, 0, 0, 0, 0, 1, 60);
    step(1, -1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 60);
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_req_c", 64'(request_c), 64'(0));
    chk("rst_req_d", 64'(request_d), 64'(0));
    chk("rst_hit",   64'(query_hit), 64'(0));
    step(1, -1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, h, v0, v1;
      r  = ($urandom_range(0, 99) == 0);
      h  = ($urandom_range(0, 9) < 3);
      v0 = mready && ($urandom_range(0, 1) == 1);
      v1 = mready && ($urandom_range(0, 1) == 1);
      drive(r, v0, $urandom_range(0, 15), $urandom, v1, $urandom_range(0, 15), $urandom,
            h, $urandom_range(0, 15));
      step(1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
